// File: rtl/kgp_minirisc_pkg.sv
// kgp_minirisc_pkg: fetch FSM encoding and instruction field layout shared across KGP miniRISC
package kgp_minirisc_pkg;
  localparam int OPCODE_W = 6;
  localparam int FUNC_W = 6;
  localparam int REG_W = 5;
  localparam int OPC_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int FUNC_LSB = 0;
  localparam int IMM16_W = 16;
  localparam int IMM26_W = 26;
  localparam logic [1:0] S_REQ = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;
endpackage

// File: rtl/ifu_perf_counters.sv
// ifu_perf_counters: pair of 32-bit saturating event counters for the fetch unit
module ifu_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_i,
  input  logic        squash_i,
  output logic [31:0] fetched_o,
  output logic [31:0] squashed_o
);
  logic [31:0] fetched_q, squashed_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetched_q <= '0;
      squashed_q <= '0;
    end else begin
      if (fetch_i && !(&fetched_q)) fetched_q <= fetched_q + 32'd1;
      if (squash_i && !(&squashed_q)) squashed_q <= squashed_q + 32'd1;
    end
  assign fetched_o = fetched_q;
  assign squashed_o = squashed_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: KGP miniRISC fetch stage, one outstanding imem request, valid/ready handoff.
// Define IFU_PERF_CNT_EN to add saturating handoff/squash counters; otherwise the perf ports read 0.
module instr_fetch_unit
  import kgp_minirisc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                halt_req,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC_W-1:0]   func,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [15:0]         imm16,
  output logic [25:0]         imm26,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [ADDR_W-1:0]   id_pc_plus4,
  output logic                halted,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_squashed
);
  logic [1:0] state_q, state_d;
  logic squash_q, squash_d, halt_q, id_valid_q, id_valid_d, take;
  logic [ADDR_W-1:0] pc_q, pc_d, id_pc_q, id_pc4_q;
  logic [31:0] instr_q;
  // A response is only captured if it belongs to a live fetch and no redirect kills it this cycle
  assign take = state_q == S_WAIT && imem_rvalid && !squash_q && !redirect_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_REQ;
      squash_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      squash_q <= squash_d;
      pc_q <= pc_d;
    end
  always_comb begin
    state_d = state_q;
    squash_d = squash_q;
    case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
        squash_d = redirect_valid;
      end
      S_WAIT: begin
        state_d = imem_rvalid ? (take ? S_HOLD : S_REQ) : S_WAIT;
        squash_d = !imem_rvalid && (squash_q || redirect_valid);
      end
      S_HOLD: state_d = redirect_valid ? S_REQ : !id_ready ? S_HOLD : (halt_req || halt_q) ? S_HALT : S_REQ;
      default: state_d = S_HALT;
    endcase
    pc_d = (redirect_valid && state_q != S_HALT) ? (redirect_pc & ~ADDR_W'(3)) :
           take ? pc_q + ADDR_W'(4) : pc_q;
    id_valid_d = take || (id_valid_q && !redirect_valid && !id_ready);
  end
  always_comb begin
    imem_req = rst_n && state_q == S_REQ;
    imem_addr = imem_req ? pc_q : '0;
    halted = state_q == S_HALT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      halt_q <= 1'b0;
      instr_q <= '0;
      id_pc_q <= '0;
      id_pc4_q <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      halt_q <= halt_q || halt_req;
      if (take) begin
        instr_q <= imem_rdata;
        id_pc_q <= pc_q;
        id_pc4_q <= pc_q + ADDR_W'(4);
      end
    end
  assign id_valid = id_valid_q;
  assign opcode = instr_q[OPC_LSB +: OPCODE_W];
  assign func = instr_q[FUNC_LSB +: FUNC_W];
  assign rs = instr_q[RS_LSB +: REG_W];
  assign rt = instr_q[RT_LSB +: REG_W];
  assign imm16 = instr_q[0 +: IMM16_W];
  assign imm26 = instr_q[0 +: IMM26_W];
  assign id_pc = id_pc_q;
  assign id_pc_plus4 = id_pc4_q;
`ifdef IFU_PERF_CNT_EN
  logic fire, kill;
  assign fire = state_q == S_HOLD && id_ready && !redirect_valid;
  // An already-squashed fetch in S_WAIT was counted when it was first killed
  assign kill = redirect_valid && (state_q == S_REQ || state_q == S_HOLD || (state_q == S_WAIT && !squash_q));
  ifu_perf_counters u_perf (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_i(fire),
    .squash_i(kill),
    .fetched_o(perf_fetched),
    .squashed_o(perf_squashed)
  );
`else
  assign perf_fetched = '0;
  assign perf_squashed = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: transaction-level fetch model checked every cycle plus directed literal checks
module tb_instr_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic imem_req, imem_rvalid = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
  logic id_valid, id_ready = 1'b0, halted;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, id_pc, id_pc_plus4, perf_fetched, perf_squashed;
  logic [5:0] opcode, func;
  logic [4:0] rs, rt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic w_req, w_rvalid = 1'b0, w_valid, w_halted;
  logic [31:0] w_addr, w_rdata = '0, w_id_pc, w_pc4, w_pf, w_ps;
  logic [5:0] w_opcode, w_func;
  logic [4:0] w_rs, w_rt;
  logic [15:0] w_imm16;
  logic [25:0] w_imm26;
  int errors = 0, checks = 0, lat = 1, cnt = 0;
  logic [31:0] raddr = '0;
  logic w_pend = 1'b0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .id_valid(id_valid), .id_ready(id_ready),
    .opcode(opcode), .func(func), .rs(rs), .rt(rt), .imm16(imm16), .imm26(imm26),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .halted(halted),
    .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .halt_req(1'b0), .id_valid(w_valid), .id_ready(1'b1),
    .opcode(w_opcode), .func(w_func), .rs(w_rs), .rt(w_rt), .imm16(w_imm16), .imm26(w_imm26),
    .id_pc(w_id_pc), .id_pc_plus4(w_pc4), .halted(w_halted),
    .perf_fetched(w_pf), .perf_squashed(w_ps)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0001 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: answers each request `lat` cycles later; junk on the bus otherwise
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = word_at(raddr);
      end
    end
    if (imem_req) begin
      cnt = lat;
      raddr = imem_addr;
    end
  end

  always @(negedge clk) begin
    w_rvalid = w_pend;
    w_rdata = w_pend ? 32'h1234_ABCD : 32'h0;
    w_pend = w_req;
  end

  // Model: fetch lifecycle as independent flags (request due, in flight, doomed, presenting, halted)
  bit m_req, m_out, m_dead, m_pres, m_halt, m_hp, redir, hp;
  logic [31:0] m_pc, m_word, m_idpc, m_fet, m_sq;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_fields", {opcode, func, rs, rt, imm16}, 0);
      chk("rst_pcs", {id_pc, id_pc_plus4}, 0);
      chk("rst_perf", {perf_fetched, perf_squashed}, 0);
      m_req = 1; m_out = 0; m_dead = 0; m_pres = 0; m_halt = 0; m_hp = 0;
      m_pc = 32'h0; m_word = '0; m_idpc = '0; m_fet = '0; m_sq = '0;
    end else begin
      chk("imem_req", imem_req, m_req);
      chk("imem_addr", imem_addr, m_req ? m_pc : 32'h0);
      chk("id_valid", id_valid, m_pres);
      chk("halted", halted, m_halt);
      if (m_pres) begin
        chk("opcode", opcode, m_word[31:26]);
        chk("func", func, m_word[5:0]);
        chk("rs_rt", {rs, rt}, m_word[25:16]);
        chk("imm16", imm16, m_word[15:0]);
        chk("imm26", imm26, m_word[25:0]);
        chk("id_pc", id_pc, m_idpc);
        chk("id_pc_plus4", id_pc_plus4, m_idpc + 32'd4);
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fet);
      chk("perf_squashed", perf_squashed, m_sq);
`else
      chk("perf_tied", {perf_fetched, perf_squashed}, 0);
`endif
      redir = redirect_valid && !m_halt;
      hp = m_hp || halt_req;
      m_hp = hp;
      if (redir && (m_req || m_pres || (m_out && !m_dead))) m_sq++;
      if (m_halt) begin
      end else if (m_req) begin
        m_req = 0; m_out = 1; m_dead = redirect_valid;
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_out = 0;
          if (m_dead || redirect_valid) m_req = 1;
          else begin
            m_pres = 1; m_word = imem_rdata; m_idpc = m_pc; m_pc = m_pc + 32'd4;
          end
        end else if (redirect_valid) m_dead = 1;
      end else if (m_pres) begin
        if (redirect_valid) begin
          m_pres = 0; m_req = 1;
        end else if (id_ready) begin
          m_pres = 0; m_fet++;
          if (hp) m_halt = 1;
          else m_req = 1;
        end
      end
      if (redir) m_pc = {redirect_pc[31:2], 2'b00};
    end
  end

  // Wrap-around instance: reset PC at the top of the address space
  initial begin
    @(posedge rst_n);
    step();
    chk("w_req", w_req, 1);
    chk("w_addr", w_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk("w_valid", w_valid, 1);
    chk("w_id_pc", w_id_pc, 32'hFFFF_FFFC);
    chk("w_pc_plus4", w_pc4, 32'h0);
    chk("w_imm16", w_imm16, 16'hABCD);
    step();
    chk("w_req2", w_req, 1);
    chk("w_addr2", w_addr, 32'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit saw, found;
  logic [31:0] pf;
  logic [15:0] ready_pat = 16'b1011_0010_1110_0101;
  initial begin
    repeat (3) step();
    chk("reset_id_valid", id_valid, 0);
    chk("reset_imem_req", imem_req, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    step();
    chk("t1_valid_early", id_valid, 0);
    step();
    chk("t1_valid", id_valid, 1);
    chk("t1_opcode", opcode, 6'h0);
    chk("t1_func", func, 6'h1);
    chk("t1_id_pc", id_pc, 32'h0);
    chk("t1_pc_plus4", id_pc_plus4, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", id_valid, 1);
      chk("t2_hold_func", func, 6'h1);
      chk("t2_no_req", imem_req, 0);
    end
    @(posedge clk); #1 id_ready = 1'b1; lat = 3;
    step();
    chk("t2_valid_before_handoff", id_valid, 1);
    step();
    chk("t2_req", imem_req, 1);
    chk("t2_addr", imem_addr, 32'h4);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(posedge clk); #1 redirect_valid = 1'b0; lat = 1; id_ready = 1'b0;
    saw = 0; found = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (id_valid) saw = 1;
      if (imem_req) begin
        found = 1;
        break;
      end
    end
    chk("t3_stale_presented", saw, 0);
    chk("t3_req_seen", found, 1);
    chk("t3_addr", imem_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (id_valid) begin
        found = 1;
        break;
      end
    end
    chk("t4_valid_seen", found, 1);
    chk("t4_id_pc", id_pc, 32'h100);
    pf = perf_fetched;
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
    @(posedge clk); #1 redirect_valid = 1'b0;
    step();
    chk("t4_killed_valid", id_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_no_handoff", perf_fetched, pf);
    @(posedge clk); #1 halt_req = 1'b1;
    @(posedge clk); #1 halt_req = 1'b0;
    step();
    chk("t5_valid", id_valid, 1);
    chk("t5_id_pc", id_pc, 32'h200);
    step();
    chk("t5_halted", halted, 1);
    chk("t5_valid_gone", id_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 redirect_valid = (i == 2); redirect_pc = 32'h400;
      step();
      chk("t5_no_req", imem_req, 0);
      chk("t5_stay_halted", halted, 1);
    end
    redirect_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_async_halted", halted, 0);
    chk("t6_async_req", imem_req, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; lat = 3;
    step();
    chk("t6_req", imem_req, 1);
    chk("t6_addr", imem_addr, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_mid_req", imem_req, 0);
    chk("t6_mid_valid", id_valid, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1; lat = 2;
    step();
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      id_ready = ready_pat[i % 16];
      redirect_valid = (i % 9 == 4);
      redirect_pc = 32'h300 + 32'(i * 12) + 32'h2;
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    repeat (10) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
